// File: rtl/dff_reset_reg.sv
// Parameterized D-type register pipeline with synchronous active-low reset and load enable.
// A valid flag travels with the data so q_valid marks post-reset data at the last stage.
module dff_reset_reg #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned STAGES    = 1,
  parameter logic [63:0] RESET_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  localparam logic [WIDTH-1:0] RstVal = RESET_VAL[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > 64) begin : gen_bad_width
    $error("dff_reset_reg: WIDTH must be in 1..64");
  end
  if (STAGES < 1 || STAGES > 8) begin : gen_bad_stages
    $error("dff_reset_reg: STAGES must be in 1..8");
  end

  logic [WIDTH-1:0] s_q [STAGES];
  logic [STAGES-1:0] v_q;

  // Reset wins over en; with en low every stage holds, so d (even X) never enters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        s_q[i] <= RstVal;
      end
      v_q <= '0;
    end else if (en) begin
      s_q[0]  <= d;
      v_q[0]  <= 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        s_q[i] <= s_q[i-1];
        v_q[i] <= v_q[i-1];
      end
    end
  end

  assign q       = s_q[STAGES-1];
  assign q_valid = v_q[STAGES-1];

endmodule

// File: tb/tb_dff_reset_reg.sv
// Scoreboard bench for dff_reset_reg: default configuration and an 8-bit, 3-stage pipeline.
module tb_dff_reset_reg;

  typedef struct packed {
    logic [7:0] q;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration DUT
  logic       rst1 = 1'b1;
  logic       en1  = 1'b0;
  logic [0:0] d1   = 1'b0;
  logic [0:0] q1;
  logic       v1;

  // WIDTH=8, STAGES=3, RESET_VAL=A5 DUT
  logic       rst8 = 1'b1;
  logic       en8  = 1'b0;
  logic [7:0] d8   = 8'h00;
  logic [7:0] q8;
  logic       v8;

  dff_reset_reg u_dut1 (
    .clk     (clk),
    .reset   (rst1),
    .en      (en1),
    .d       (d1),
    .q       (q1),
    .q_valid (v1)
  );

  dff_reset_reg #(
    .WIDTH     (8),
    .STAGES    (3),
    .RESET_VAL (64'hA5)
  ) u_dut8 (
    .clk     (clk),
    .reset   (rst8),
    .en      (en8),
    .d       (d8),
    .q       (q8),
    .q_valid (v8)
  );

  exp_t exp1_q[$];
  exp_t exp8_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n1 = 0;
  int   n8 = 0;

  // Monitors: after each rising edge, compare against any pending expectation.
  always @(posedge clk) begin
    #1;
    if (exp1_q.size() > 0) begin
      exp_t e;
      e = exp1_q.pop_front();
      checks++;
      n1++;
      if (q1 !== e.q[0:0] || v1 !== e.v) begin
        errors++;
        $display("FAIL dut1_step%0d: got q=%b q_valid=%b, expected q=%b q_valid=%b",
                 n1, q1, v1, e.q[0], e.v);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (exp8_q.size() > 0) begin
      exp_t e;
      e = exp8_q.pop_front();
      checks++;
      n8++;
      if (q8 !== e.q || v8 !== e.v) begin
        errors++;
        $display("FAIL dut8_step%0d: got q=%h q_valid=%b, expected q=%h q_valid=%b",
                 n8, q8, v8, e.q, e.v);
      end
    end
  end

  task automatic step1(input logic r, input logic e, input logic dv,
                       input logic eq, input logic ev);
    @(negedge clk);
    rst1 = r;
    en1  = e;
    d1   = dv;
    exp1_q.push_back('{q: {7'd0, eq}, v: ev});
  endtask

  task automatic step8(input logic r, input logic e, input logic [7:0] dv,
                       input logic [7:0] eq, input logic ev);
    @(negedge clk);
    rst8 = r;
    en8  = e;
    d8   = dv;
    exp8_q.push_back('{q: eq, v: ev});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Default configuration
    step1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // reset overrides en
    step1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);  // load with no recovery delay
    step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // Short reset pulse between edges must be ignored
    @(negedge clk);
    en1 = 1'b0;
    exp1_q.push_back('{q: 8'd1, v: 1'b1});
    #1 rst1 = 1'b0;
    #3 rst1 = 1'b1;
    step1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // reset held across an edge
    step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // en low holds reset state
    step1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    en1 = 1'b0;

    // Pipeline configuration
    step8(1'b0, 1'b1, 8'hFF, 8'hA5, 1'b0);
    step8(1'b1, 1'b1, 8'h11, 8'hA5, 1'b0);
    step8(1'b1, 1'b1, 8'h22, 8'hA5, 1'b0);
    step8(1'b1, 1'b1, 8'h33, 8'h11, 1'b1);
    step8(1'b1, 1'b1, 8'h44, 8'h22, 1'b1);
    step8(1'b1, 1'b0, 8'hxx, 8'h22, 1'b1);  // stall, X on d ignored
    step8(1'b1, 1'b0, 8'hEE, 8'h22, 1'b1);
    step8(1'b1, 1'b1, 8'h55, 8'h33, 1'b1);
    step8(1'b1, 1'b1, 8'h66, 8'h44, 1'b1);
    step8(1'b1, 1'b1, 8'h77, 8'h55, 1'b1);
    step8(1'b0, 1'b1, 8'hFF, 8'hA5, 1'b0);  // reset discards in-flight data
    step8(1'b1, 1'b1, 8'h01, 8'hA5, 1'b0);
    step8(1'b1, 1'b1, 8'h02, 8'hA5, 1'b0);
    step8(1'b1, 1'b1, 8'h03, 8'h01, 1'b1);
    step8(1'b1, 1'b0, 8'h04, 8'h01, 1'b1);

    repeat (3) @(negedge clk);
    if (exp1_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0/0",
               exp1_q.size(), exp8_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
